session_ctrl: RTL and testbench
===============================

Name: session_ctrl

Overview:
Session layer of the FPGA telephone. It sits between the keypad/UI, the AC97 audio path and the transport layer. It runs the call-setup state machine (dial, ring, answer, reject, hang-up) using 16-bit control packets, and moves voice samples between the mic/speaker FIFOs and transport while a call is connected.

Parameters:
FIFO_DEPTH, 16, words in each of the mic and speaker FIFOs (power of two).
TIMEOUT_CYCLES, 1000000, unanswered-call limit in clk cycles (used only with CALL_TIMEOUT_EN).

Ports:
clk  in  1  system clock; all state updates on its rising edge
reset  in  1  asynchronous, active-low reset
phoneNum  in  8  number to dial; sampled with userInp=0x01
userInp  in  5  UI command: 0x01 dial, 0x02 answer, 0x03 hang up, 0x04 reject; others ignored
cmdIn  in  2  transport receive strobe: 00 none, 01 control packet, 10 voice word, 11 ignored
packetIn  in  16  control packet = {peer number[15:8], opcode[7:0]}, or a voice word
transportBusy  in  1  1 = transport cannot accept a command this cycle
micFlag  out  1  1 while CONNECTED (enables mic capture)
cmd  out  2  transmit command: 00 none, 01 control, 10 voice; valid for one cycle
dataOut  out  16  payload for cmd
sessionBusy  out  1  1 whenever current_state is not IDLE
phoneOut  out  8  peer number of the current session; 0 in IDLE
current_state  out  4  state encoding (see Behaviour)
ac97_clk  in  1  synchronous sample strobe (clk domain) qualifying FIFO accesses
micBuffer_wr_en  in  1  mic FIFO push request
micBufferIn  in  16  mic sample
spkBuffer_rd_en  in  1  speaker FIFO pop request
spkBufferOut  out  16  speaker FIFO head (first-word fall-through)
micBufferFull, micBufferEmpty, spkBufferFull, spkBufferEmpty  out  1 each  FIFO flags

Behaviour:
- Control opcodes: 0x01 CALL_REQ, 0x02 ACCEPT, 0x03 REJECT, 0x04 HANGUP, 0x05 RINGING.
- Reset values: state IDLE, remote number 0, cmd 00, dataOut 0, micFlag 0, sessionBusy 0, phoneOut 0, spkBufferOut 0. Both FIFOs are emptied (Empty=1, Full=0). Reset asserted mid-call aborts the call and sends nothing.
- Transmit handshake: a pending message is issued as cmd/dataOut for exactly one cycle in which transportBusy=0. While busy, cmd=00 and the message stays pending. Priority order: auto-reject, then state control message, then voice.
- State encodings: 0 IDLE, 1 DIALING, 2 WAIT_ANSWER, 3 REMOTE_RING, 4 INCOMING, 5 CONNECTED, 6 HANGUP, 7 ACCEPTING, 8 REJECTING.
- IDLE:
  - Received CALL_REQ: latch the peer number and go to INCOMING.
  - Otherwise, userInp=0x01 with phoneNum≠0: latch phoneNum and go to DIALING.
  - A received CALL_REQ wins over a simultaneous dial. Dialing 0x00 is ignored.
- DIALING: send {remote,0x01}, then go to WAIT_ANSWER.
- WAIT_ANSWER: RINGING goes to REMOTE_RING; ACCEPT goes to CONNECTED; REJECT or HANGUP goes to IDLE; user 0x03 goes to HANGUP.
- REMOTE_RING: same as WAIT_ANSWER, except RINGING is ignored.
- INCOMING:
  - Send {remote,0x05} once.
  - User 0x02 goes to ACCEPTING; user 0x03 or 0x04 goes to REJECTING.
  - Peer HANGUP goes to IDLE.
- ACCEPTING: send {remote,0x02}, then go to CONNECTED.
- REJECTING: send {remote,0x03}, then go to IDLE.
- HANGUP: send {remote,0x04}, then go to IDLE.
- CONNECTED: peer HANGUP goes to IDLE; user 0x03 goes to HANGUP.
- A control packet whose peer number ≠ remote (outside IDLE) is ignored, except CALL_REQ. That CALL_REQ queues an auto-reject {peer,0x03} with no state change. A second auto-reject while one is pending overwrites it.
- Control packets whose opcode is not defined for the current state are ignored.
- Mic FIFO: push on micBuffer_wr_en & ac97_clk; pushes when full are dropped.
  - In CONNECTED, when not empty and the transmit slot is free: pop one word, issue cmd=10, dataOut=word.
- Speaker FIFO: cmdIn=10 in CONNECTED pushes packetIn; pushes when full are dropped. cmdIn=10 in other states is ignored.
  - Pop on spkBuffer_rd_en & ac97_clk; pops when empty are ignored and spkBufferOut holds.
  - A simultaneous push and pop on a full or empty FIFO is handled correctly (count unchanged).
- Leaving CONNECTED flushes both FIFOs.
- phoneOut = latched remote in every state except IDLE.

Optional Feature:
CALL_TIMEOUT_EN:
- Defined: a counter runs in WAIT_ANSWER, REMOTE_RING and INCOMING, and clears on every state change. On reaching TIMEOUT_CYCLES:
  - WAIT_ANSWER or REMOTE_RING goes to HANGUP.
  - INCOMING goes to REJECTING.
- Undefined: no counter; those states wait indefinitely.

Test Plan:
- Dial: reset low→high, phoneNum=0x20, userInp=0x01 → state 1, then one cycle cmd=01/dataOut=0x2001, state 2, phoneOut=0x20, sessionBusy=1.
- Foreign peer: in state 2, cmdIn=01 packetIn=0x3005 → ignored, state 2. Then packetIn=0x3001 → one cycle cmd=01/dataOut=0x3003, still state 2.
- Incoming and answer: IDLE, packetIn=0x4401 cmdIn=01 → state 4, cmd 0x4405. Then userInp=0x02 → cmd 0x4402, state 5, micFlag=1.
- Voice: in CONNECTED push 3 mic words (ac97_clk=1) → three cmd=10 words in order. With transportBusy=1, no cmd until it drops. cmdIn=10 with 0xBEEF → spkBufferOut=0xBEEF, spkBufferEmpty=0.
- FIFO bounds: push FIFO_DEPTH+2 words → Full=1 and the extra two are dropped. Pop an empty FIFO → output held, flags unchanged.
- Hang-up: userInp=0x03 in CONNECTED → cmd 0x4404, state 0, FIFOs empty, phoneOut=0. Asserting reset mid-call → immediate IDLE, no cmd issued.

Source files
------------

// File: rtl/session_ctrl.sv
// session_ctrl: session layer of the FPGA telephone.
//
// Runs call setup and teardown (dial, ring, answer, reject, hang up) with
// 16-bit control packets {peer[15:8], opcode[7:0]}. While a call is
// CONNECTED it moves voice words from the mic FIFO to transport and from
// transport into the speaker FIFO.
//
// Ports:
//   clk, reset (async, active low)
//   phoneNum, userInp            keypad/UI number and command
//   cmdIn, packetIn              transport receive strobe and payload
//   transportBusy                transport cannot take a command this cycle
//   cmd, dataOut                 transmit strobe and payload
//   micFlag, sessionBusy         CONNECTED / not-IDLE indications
//   phoneOut, current_state      peer number and FSM state (debug visible)
//   ac97_clk                     sample strobe qualifying FIFO accesses
//   micBuffer_wr_en, micBufferIn mic FIFO push side
//   spkBuffer_rd_en, spkBufferOut speaker FIFO pop side (first-word fall-through)
//   mic/spk Full/Empty flags
//
// Optional build macro CALL_TIMEOUT_EN: adds an unanswered-call timer of
// TIMEOUT_CYCLES clocks in WAIT_ANSWER, REMOTE_RING and INCOMING.

// Small FWFT FIFO. When empty, dout holds the last word popped (0 after
// reset). A push and pop in the same cycle always leaves the count
// unchanged; on an empty FIFO the pushed word passes straight through.
module session_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] hold;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (!empty || push);
    assign dout    = empty ? hold : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                hold   <= empty ? din : mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

module session_ctrl #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  phoneNum,
    input  logic [4:0]  userInp,
    input  logic [1:0]  cmdIn,
    input  logic [15:0] packetIn,
    input  logic        transportBusy,
    output logic        micFlag,
    output logic [1:0]  cmd,
    output logic [15:0] dataOut,
    output logic        sessionBusy,
    output logic [7:0]  phoneOut,
    output logic [3:0]  current_state,
    input  logic        ac97_clk,
    input  logic        micBuffer_wr_en,
    input  logic [15:0] micBufferIn,
    input  logic        spkBuffer_rd_en,
    output logic [15:0] spkBufferOut,
    output logic        micBufferFull,
    output logic        micBufferEmpty,
    output logic        spkBufferFull,
    output logic        spkBufferEmpty
);
    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_DIALING     = 4'd1,
        S_WAIT_ANSWER = 4'd2,
        S_REMOTE_RING = 4'd3,
        S_INCOMING    = 4'd4,
        S_CONNECTED   = 4'd5,
        S_HANGUP      = 4'd6,
        S_ACCEPTING   = 4'd7,
        S_REJECTING   = 4'd8
    } state_t;

    localparam logic [7:0] OP_CALL_REQ = 8'h01;
    localparam logic [7:0] OP_ACCEPT   = 8'h02;
    localparam logic [7:0] OP_REJECT   = 8'h03;
    localparam logic [7:0] OP_HANGUP   = 8'h04;
    localparam logic [7:0] OP_RINGING  = 8'h05;

    localparam logic [4:0] UI_DIAL   = 5'h01;
    localparam logic [4:0] UI_ANSWER = 5'h02;
    localparam logic [4:0] UI_HANGUP = 5'h03;
    localparam logic [4:0] UI_REJECT = 5'h04;

    state_t      state, next_state;
    logic [7:0]  remote;
    logic        ring_sent;      // RINGING already sent in this INCOMING visit
    logic        arej_pend;
    logic [7:0]  arej_peer;
    logic        load_remote;
    logic [7:0]  load_val;
    logic        timeout;

    logic        rx_ctrl, rx_match, foreign_req;
    logic [7:0]  rx_peer, rx_op;

    logic        msg_valid;
    logic [15:0] msg_word;
    logic        ctrl_sent, arej_sent, mic_pop;
    logic        fifo_flush, spk_push;
    logic [15:0] mic_head;

    assign rx_ctrl     = (cmdIn == 2'b01);
    assign rx_peer     = packetIn[15:8];
    assign rx_op       = packetIn[7:0];
    assign rx_match    = rx_ctrl && (rx_peer == remote);
    // A stranger calling while we are busy gets an automatic REJECT.
    assign foreign_req = rx_ctrl && (state != S_IDLE) && (rx_peer != remote)
                         && (rx_op == OP_CALL_REQ);

    // Control message owed by the current state, if any.
    always_comb begin
        msg_valid = 1'b0;
        msg_word  = '0;
        case (state)
            S_DIALING:   begin msg_valid = 1'b1;       msg_word = {remote, OP_CALL_REQ}; end
            S_INCOMING:  begin msg_valid = !ring_sent; msg_word = {remote, OP_RINGING};  end
            S_ACCEPTING: begin msg_valid = 1'b1;       msg_word = {remote, OP_ACCEPT};   end
            S_REJECTING: begin msg_valid = 1'b1;       msg_word = {remote, OP_REJECT};   end
            S_HANGUP:    begin msg_valid = 1'b1;       msg_word = {remote, OP_HANGUP};   end
            default:     ;
        endcase
    end

    // Transmit handshake: cmd != 00 is a one-cycle valid strobe and
    // !transportBusy is its ready; cmd is only raised when ready, so every
    // non-zero cmd cycle is a completed transfer. Anything not sent stays
    // pending. Order: auto-reject, state message, voice.
    always_comb begin
        cmd       = 2'b00;
        dataOut   = '0;
        arej_sent = 1'b0;
        ctrl_sent = 1'b0;
        mic_pop   = 1'b0;
        if (!transportBusy) begin
            if (arej_pend) begin
                cmd       = 2'b01;
                dataOut   = {arej_peer, OP_REJECT};
                arej_sent = 1'b1;
            end else if (msg_valid) begin
                cmd       = 2'b01;
                dataOut   = msg_word;
                ctrl_sent = 1'b1;
            end else if (state == S_CONNECTED && !micBufferEmpty) begin
                cmd       = 2'b10;
                dataOut   = mic_head;
                mic_pop   = 1'b1;
            end
        end
    end

    always_comb begin
        next_state  = state;
        load_remote = 1'b0;
        load_val    = '0;
        case (state)
            S_IDLE: begin
                if (rx_ctrl && rx_op == OP_CALL_REQ) begin
                    next_state  = S_INCOMING;
                    load_remote = 1'b1;
                    load_val    = rx_peer;
                end else if (userInp == UI_DIAL && phoneNum != 8'h00) begin
                    next_state  = S_DIALING;
                    load_remote = 1'b1;
                    load_val    = phoneNum;
                end
            end
            S_DIALING: if (ctrl_sent) next_state = S_WAIT_ANSWER;
            S_WAIT_ANSWER, S_REMOTE_RING: begin
                if (rx_match && rx_op == OP_RINGING && state == S_WAIT_ANSWER)
                    next_state = S_REMOTE_RING;
                else if (rx_match && rx_op == OP_ACCEPT)
                    next_state = S_CONNECTED;
                else if (rx_match && (rx_op == OP_REJECT || rx_op == OP_HANGUP))
                    next_state = S_IDLE;
                else if (userInp == UI_HANGUP || timeout)
                    next_state = S_HANGUP;
            end
            S_INCOMING: begin
                if (rx_match && rx_op == OP_HANGUP)
                    next_state = S_IDLE;
                else if (userInp == UI_ANSWER)
                    next_state = S_ACCEPTING;
                else if (userInp == UI_HANGUP || userInp == UI_REJECT || timeout)
                    next_state = S_REJECTING;
            end
            S_CONNECTED: begin
                if (rx_match && rx_op == OP_HANGUP) next_state = S_IDLE;
                else if (userInp == UI_HANGUP)      next_state = S_HANGUP;
            end
            S_ACCEPTING: if (ctrl_sent) next_state = S_CONNECTED;
            S_REJECTING, S_HANGUP: if (ctrl_sent) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            remote    <= '0;
            ring_sent <= 1'b0;
            arej_pend <= 1'b0;
            arej_peer <= '0;
        end else begin
            state     <= next_state;
            if (load_remote) remote <= load_val;
            ring_sent <= (state == S_INCOMING) && (next_state == S_INCOMING)
                         && (ring_sent || ctrl_sent);
            // A new foreign CALL_REQ overwrites any reject still pending.
            if (foreign_req) begin
                arej_pend <= 1'b1;
                arej_peer <= rx_peer;
            end else if (arej_sent) begin
                arej_pend <= 1'b0;
            end
        end
    end

`ifdef CALL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
    logic          timed_state;

    assign timed_state = (state == S_WAIT_ANSWER) || (state == S_REMOTE_RING)
                         || (state == S_INCOMING);
    assign timeout     = timed_state && (wait_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                 wait_cnt <= '0;
        else if (!timed_state || next_state != state) wait_cnt <= '0;
        else                                        wait_cnt <= wait_cnt + TW'(1);
    end
`else
    // No timer: unanswered calls wait forever (expression is constant 0).
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    assign fifo_flush = (state == S_CONNECTED) && (next_state != S_CONNECTED);
    assign spk_push   = (cmdIn == 2'b10) && (state == S_CONNECTED);

    session_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_mic_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (micBuffer_wr_en && ac97_clk),
        .pop   (mic_pop),
        .din   (micBufferIn),
        .dout  (mic_head),
        .empty (micBufferEmpty),
        .full  (micBufferFull)
    );

    session_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_spk_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (spk_push),
        .pop   (spkBuffer_rd_en && ac97_clk),
        .din   (packetIn),
        .dout  (spkBufferOut),
        .empty (spkBufferEmpty),
        .full  (spkBufferFull)
    );

    assign micFlag       = (state == S_CONNECTED);
    assign sessionBusy   = (state != S_IDLE);
    assign phoneOut      = (state == S_IDLE) ? 8'h00 : remote;
    assign current_state = state;
endmodule

// File: tb/tb_session_ctrl.sv
// Bench for session_ctrl: table of per-cycle vectors for call setup, then
// hand-written sequences for voice transfer, FIFO bounds, hang-up and
// reset in the middle of a call.
module tb_session_ctrl;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  phoneNum;
    logic [4:0]  userInp;
    logic [1:0]  cmdIn;
    logic [15:0] packetIn;
    logic        transportBusy;
    logic        micFlag;
    logic [1:0]  cmd;
    logic [15:0] dataOut;
    logic        sessionBusy;
    logic [7:0]  phoneOut;
    logic [3:0]  current_state;
    logic        ac97_clk;
    logic        micBuffer_wr_en;
    logic [15:0] micBufferIn;
    logic        spkBuffer_rd_en;
    logic [15:0] spkBufferOut;
    logic        micBufferFull, micBufferEmpty, spkBufferFull, spkBufferEmpty;

    session_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(1000000)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .phoneNum        (phoneNum),
        .userInp         (userInp),
        .cmdIn           (cmdIn),
        .packetIn        (packetIn),
        .transportBusy   (transportBusy),
        .micFlag         (micFlag),
        .cmd             (cmd),
        .dataOut         (dataOut),
        .sessionBusy     (sessionBusy),
        .phoneOut        (phoneOut),
        .current_state   (current_state),
        .ac97_clk        (ac97_clk),
        .micBuffer_wr_en (micBuffer_wr_en),
        .micBufferIn     (micBufferIn),
        .spkBuffer_rd_en (spkBuffer_rd_en),
        .spkBufferOut    (spkBufferOut),
        .micBufferFull   (micBufferFull),
        .micBufferEmpty  (micBufferEmpty),
        .spkBufferFull   (spkBufferFull),
        .spkBufferEmpty  (spkBufferEmpty)
    );

    // Clock and reset
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  user;
        logic [7:0]  num;
        logic [1:0]  cin;
        logic [15:0] pkt;
        logic        busy;
        logic [3:0]  e_state;
        logic [1:0]  e_cmd;
        logic [15:0] e_data;
        logic [7:0]  e_phone;
        logic        e_sbusy;
        logic        e_mic;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        userInp         = 5'h00;
        phoneNum        = 8'h00;
        cmdIn           = 2'b00;
        packetIn        = 16'h0000;
        transportBusy   = 1'b0;
        ac97_clk        = 1'b0;
        micBuffer_wr_en = 1'b0;
        micBufferIn     = 16'h0000;
        spkBuffer_rd_en = 1'b0;
    endtask

    task automatic add(input logic [4:0] u, input logic [7:0] n, input logic [1:0] ci,
                       input logic [15:0] p, input logic b, input logic [3:0] es,
                       input logic [1:0] ec, input logic [15:0] ed, input logic [7:0] ep,
                       input logic esb, input logic em);
        vec_t v;
        v.user = u; v.num = n; v.cin = ci; v.pkt = p; v.busy = b;
        v.e_state = es; v.e_cmd = ec; v.e_data = ed; v.e_phone = ep;
        v.e_sbusy = esb; v.e_mic = em;
        vecs.push_back(v);
    endtask

    logic [15:0] words[3];

    initial begin
        // Call-setup vectors: inputs for this cycle, outputs expected this
        // cycle (state shown is the one before the coming clock edge).
        add(5'h01, 8'h20, 2'b00, 16'h0000, 1'b0, 4'd0, 2'b00, 16'h0000, 8'h00, 1'b0, 1'b0); // dial 0x20
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd1, 2'b01, 16'h2001, 8'h20, 1'b1, 1'b0); // CALL_REQ out
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd2, 2'b00, 16'h0000, 8'h20, 1'b1, 1'b0);
        add(5'h00, 8'h00, 2'b01, 16'h3005, 1'b0, 4'd2, 2'b00, 16'h0000, 8'h20, 1'b1, 1'b0); // foreign RINGING
        add(5'h00, 8'h00, 2'b01, 16'h3001, 1'b0, 4'd2, 2'b00, 16'h0000, 8'h20, 1'b1, 1'b0); // foreign CALL_REQ
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd2, 2'b01, 16'h3003, 8'h20, 1'b1, 1'b0); // auto-reject
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd2, 2'b00, 16'h0000, 8'h20, 1'b1, 1'b0);
        add(5'h00, 8'h00, 2'b01, 16'h5501, 1'b1, 4'd2, 2'b00, 16'h0000, 8'h20, 1'b1, 1'b0); // busy
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b1, 4'd2, 2'b00, 16'h0000, 8'h20, 1'b1, 1'b0);
        add(5'h00, 8'h00, 2'b01, 16'h6601, 1'b1, 4'd2, 2'b00, 16'h0000, 8'h20, 1'b1, 1'b0); // overwrite
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd2, 2'b01, 16'h6603, 8'h20, 1'b1, 1'b0);
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd2, 2'b00, 16'h0000, 8'h20, 1'b1, 1'b0);
        add(5'h00, 8'h00, 2'b01, 16'h2005, 1'b0, 4'd2, 2'b00, 16'h0000, 8'h20, 1'b1, 1'b0); // peer RINGING
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd3, 2'b00, 16'h0000, 8'h20, 1'b1, 1'b0);
        add(5'h00, 8'h00, 2'b01, 16'h2005, 1'b0, 4'd3, 2'b00, 16'h0000, 8'h20, 1'b1, 1'b0); // ignored
        add(5'h00, 8'h00, 2'b01, 16'h2099, 1'b0, 4'd3, 2'b00, 16'h0000, 8'h20, 1'b1, 1'b0); // bad opcode
        add(5'h03, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd3, 2'b00, 16'h0000, 8'h20, 1'b1, 1'b0); // user hang up
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b1, 4'd6, 2'b00, 16'h0000, 8'h20, 1'b1, 1'b0);
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd6, 2'b01, 16'h2004, 8'h20, 1'b1, 1'b0);
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd0, 2'b00, 16'h0000, 8'h00, 1'b0, 1'b0);
        add(5'h01, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd0, 2'b00, 16'h0000, 8'h00, 1'b0, 1'b0); // dial 0
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd0, 2'b00, 16'h0000, 8'h00, 1'b0, 1'b0);
        add(5'h01, 8'h20, 2'b01, 16'h4401, 1'b0, 4'd0, 2'b00, 16'h0000, 8'h00, 1'b0, 1'b0); // rx beats dial
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd4, 2'b01, 16'h4405, 8'h44, 1'b1, 1'b0);
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd4, 2'b00, 16'h0000, 8'h44, 1'b1, 1'b0); // sent once
        add(5'h02, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd4, 2'b00, 16'h0000, 8'h44, 1'b1, 1'b0); // answer
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd7, 2'b01, 16'h4402, 8'h44, 1'b1, 1'b0);
        add(5'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 4'd5, 2'b00, 16'h0000, 8'h44, 1'b1, 1'b1);

        set_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst state", 16'(current_state), 16'h0);
        chk("rst cmd", 16'(cmd), 16'h0);
        chk("rst dataOut", dataOut, 16'h0);
        chk("rst micFlag", 16'(micFlag), 16'h0);
        chk("rst sessionBusy", 16'(sessionBusy), 16'h0);
        chk("rst phoneOut", 16'(phoneOut), 16'h0);
        chk("rst spkBufferOut", spkBufferOut, 16'h0);
        chk("rst flags", 16'({micBufferEmpty, micBufferFull, spkBufferEmpty, spkBufferFull}), 16'b1010);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            userInp       = vecs[i].user;
            phoneNum      = vecs[i].num;
            cmdIn         = vecs[i].cin;
            packetIn      = vecs[i].pkt;
            transportBusy = vecs[i].busy;
            #1;
            chk($sformatf("v%0d state", i), 16'(current_state), 16'(vecs[i].e_state));
            chk($sformatf("v%0d cmd", i), 16'(cmd), 16'(vecs[i].e_cmd));
            if (vecs[i].e_cmd != 2'b00)
                chk($sformatf("v%0d dataOut", i), dataOut, vecs[i].e_data);
            chk($sformatf("v%0d phoneOut", i), 16'(phoneOut), 16'(vecs[i].e_phone));
            chk($sformatf("v%0d sessionBusy", i), 16'(sessionBusy), 16'(vecs[i].e_sbusy));
            chk($sformatf("v%0d micFlag", i), 16'(micFlag), 16'(vecs[i].e_mic));
            @(negedge clk);
        end
        set_idle();

        // Voice out: three mic words queued while transport is busy.
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            micBuffer_wr_en = 1'b1; ac97_clk = 1'b1; micBufferIn = words[i];
            transportBusy = 1'b1;
            exp_q.push_back(words[i]);
            #1 chk("voice busy cmd", 16'(cmd), 16'h0);
            @(negedge clk);
        end
        set_idle();
        transportBusy = 1'b1;
        #1 chk("voice held cmd", 16'(cmd), 16'h0);
        chk("voice mic nonempty", 16'(micBufferEmpty), 16'h0);
        @(negedge clk);
        transportBusy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("voice cmd", 16'(cmd), 16'h2);
            chk("voice word", dataOut, exp_q.pop_front());
            @(negedge clk);
        end
        #1 chk("voice drained cmd", 16'(cmd), 16'h0);
        chk("voice mic empty", 16'(micBufferEmpty), 16'h1);
        @(negedge clk);

        // Voice in: one speaker word, then pop it and pop once more when empty.
        cmdIn = 2'b10; packetIn = 16'hBEEF;
        @(negedge clk);
        set_idle();
        #1 chk("spk head", spkBufferOut, 16'hBEEF);
        chk("spk nonempty", 16'(spkBufferEmpty), 16'h0);
        @(negedge clk);
        spkBuffer_rd_en = 1'b1; ac97_clk = 1'b1;
        @(negedge clk);
        #1 chk("spk popped hold", spkBufferOut, 16'hBEEF);
        chk("spk empty", 16'(spkBufferEmpty), 16'h1);
        @(negedge clk);
        set_idle();
        #1 chk("spk empty pop hold", spkBufferOut, 16'hBEEF);
        chk("spk empty pop flags", 16'({spkBufferEmpty, spkBufferFull}), 16'b10);

        // Speaker FIFO bounds: DEPTH+2 pushes, the last two dropped.
        for (int i = 0; i < DEPTH + 2; i++) begin
            cmdIn = 2'b10; packetIn = 16'h1000 + 16'(i);
            if (exp_q.size() < DEPTH) exp_q.push_back(packetIn);
            @(negedge clk);
        end
        set_idle();
        #1 chk("spk full", 16'({spkBufferEmpty, spkBufferFull}), 16'b01);
        // Push and pop together while full: count stays at DEPTH.
        cmdIn = 2'b10; packetIn = 16'h2000; spkBuffer_rd_en = 1'b1; ac97_clk = 1'b1;
        #1 chk("spk full push+pop head", spkBufferOut, exp_q.pop_front());
        exp_q.push_back(16'h2000);
        @(negedge clk);
        set_idle();
        #1 chk("spk still full", 16'(spkBufferFull), 16'h1);
        for (int i = 0; i < DEPTH; i++) begin
            spkBuffer_rd_en = 1'b1; ac97_clk = 1'b1;
            #1 chk($sformatf("spk drain %0d", i), spkBufferOut, exp_q.pop_front());
            @(negedge clk);
        end
        set_idle();
        #1 chk("spk drained flags", 16'({spkBufferEmpty, spkBufferFull}), 16'b10);
        chk("spk drained hold", spkBufferOut, 16'h2000);
        // Push and pop together while empty: stays empty.
        cmdIn = 2'b10; packetIn = 16'h7777; spkBuffer_rd_en = 1'b1; ac97_clk = 1'b1;
        @(negedge clk);
        set_idle();
        #1 chk("spk empty push+pop", 16'({spkBufferEmpty, spkBufferFull}), 16'b10);

        // Hang up from CONNECTED with data in both FIFOs.
        cmdIn = 2'b10; packetIn = 16'h5555;
        @(negedge clk);
        set_idle();
        micBuffer_wr_en = 1'b1; ac97_clk = 1'b1; micBufferIn = 16'hAAAA; transportBusy = 1'b1;
        @(negedge clk);
        set_idle();
        userInp = 5'h03; transportBusy = 1'b1;
        #1 chk("hup state", 16'(current_state), 16'h5);
        chk("hup fifos loaded", 16'({micBufferEmpty, spkBufferEmpty}), 16'b00);
        @(negedge clk);
        set_idle();
        #1 chk("hup state6", 16'(current_state), 16'h6);
        chk("hup cmd", 16'(cmd), 16'h1);
        chk("hup data", dataOut, 16'h4404);
        chk("hup fifos flushed", 16'({micBufferEmpty, spkBufferEmpty}), 16'b11);
        @(negedge clk);
        #1 chk("hup idle", 16'(current_state), 16'h0);
        chk("hup phoneOut", 16'(phoneOut), 16'h0);
        chk("hup sessionBusy", 16'(sessionBusy), 16'h0);
        @(negedge clk);

        // Reset in the middle of a call with a voice word ready to go.
        userInp = 5'h01; phoneNum = 8'h20;
        @(negedge clk);
        set_idle();
        #1 chk("rc dial cmd", dataOut, 16'h2001);
        @(negedge clk);
        cmdIn = 2'b01; packetIn = 16'h2002;
        @(negedge clk);
        set_idle();
        #1 chk("rc connected", 16'(current_state), 16'h5);
        micBuffer_wr_en = 1'b1; ac97_clk = 1'b1; micBufferIn = 16'hBBBB; transportBusy = 1'b1;
        @(negedge clk);
        set_idle();
        rst_n = 1'b0;
        #1 chk("rc state", 16'(current_state), 16'h0);
        chk("rc no cmd", 16'(cmd), 16'h0);
        chk("rc outputs", 16'({micFlag, sessionBusy, micBufferEmpty, spkBufferEmpty}), 16'b0011);
        chk("rc phoneOut", 16'(phoneOut), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("rc after release", 16'({current_state, cmd}), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
